sccb_init_seq: RTL and testbench

Parametrised, table-driven SCCB initialisation sequencer for OmniVision-class camera sensors. It steps through an external command table whose size is set by parameter, issues register writes through the SCCB master handshake, and optionally reads each register back to verify it. It also executes timed delay entries, retries failed verifies, detects a stalled bus with a timeout, and reports done or error with the index of the failing entry. It sits between the camera bring-up control and the SCCB master, and replaces the fixed-table per-sensor init blocks.

---
 rtl/sccb_init_seq_if.sv | 23 ++
 rtl/sccb_init_seq.sv | 114 +++++++++++
 tb/tb_sccb_init_seq.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sccb_init_seq_if.sv
// sccb_init_seq_if: command-table read port and SCCB master handshake for sccb_init_seq
interface sccb_init_seq_if #(parameter int TBL_AW = 6);
    logic [TBL_AW-1:0] tbl_addr;
    logic [17:0]       tbl_data;
    logic              m_start;
    logic              m_rw;
    logic [7:0]        m_addr;
    logic [7:0]        m_subaddr;
    logic [7:0]        m_wdata;
    logic [7:0]        m_rdata;
    logic              m_done;
    logic              m_busy;

    modport master (
        output tbl_addr, m_start, m_rw, m_addr, m_subaddr, m_wdata,
        input  tbl_data, m_rdata, m_done, m_busy
    );

    modport slave (
        input  tbl_addr, m_start, m_rw, m_addr, m_subaddr, m_wdata,
        output tbl_data, m_rdata, m_done, m_busy
    );
endinterface

// File: rtl/sccb_init_seq.sv
// sccb_init_seq: table-driven SCCB init sequencer with readback verify, delays, retries and bus timeout
module sccb_init_seq #(
    parameter logic [7:0] CHIP_ADDR  = 8'h42,
    parameter int         TBL_AW     = 6,
    parameter int         NUM_CMDS   = 40,
    parameter int         DELAY_UNIT = 1000,
    parameter int         MAX_RETRY  = 3,
    parameter int         TIMEOUT    = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    sccb_init_seq_if.master   bus,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [TBL_AW-1:0] err_index
);
    localparam int DW = $clog2(255 * DELAY_UNIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [3:0] MR = 4'(MAX_RETRY);

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, ISSUE, WAIT, RB_ISSUE, RB_WAIT, CHECK, DELAY, NEXT, DONE, ERROR
    } state_t;

    state_t state, state_n;
    logic [TBL_AW:0] idx;
    logic [1:0] op;
    logic [3:0] retries;
    logic [7:0] rdata;
    logic [DW-1:0] dcnt;
    logic [TW-1:0] tcnt;
    logic go, timed_out, last, mismatch;

    assign go        = start && (state == IDLE || state == DONE || state == ERROR);
    assign busy      = !(state == IDLE || state == DONE || state == ERROR);
    assign done      = state == DONE;
    assign error     = state == ERROR;
    assign timed_out = tcnt == TW'(TIMEOUT - 1);
    assign last      = idx == (TBL_AW + 1)'(NUM_CMDS - 1);
    assign mismatch  = rdata != bus.m_wdata;

    // Combinational so that reset withdraws a pending request at once.
    assign bus.m_start  = (state == ISSUE || state == RB_ISSUE) && !bus.m_busy;
    assign bus.m_rw     = bus.m_addr[0];
    assign bus.tbl_addr = idx[TBL_AW-1:0];

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE, ERROR: state_n = go ? FETCH : state;
            FETCH:    state_n = DECODE;
            DECODE:   state_n = bus.tbl_data[17:16] == 2'b11 ? DONE :
                                bus.tbl_data[17:16] == 2'b10 ? (bus.tbl_data[7:0] == 8'd0 ? NEXT : DELAY) : ISSUE;
            ISSUE:    state_n = bus.m_busy ? ISSUE : WAIT;
            WAIT:     state_n = bus.m_done ? (op == 2'b01 ? RB_ISSUE : NEXT) : timed_out ? ERROR : WAIT;
            RB_ISSUE: state_n = bus.m_busy ? RB_ISSUE : RB_WAIT;
            RB_WAIT:  state_n = bus.m_done ? CHECK : timed_out ? ERROR : RB_WAIT;
            CHECK:    state_n = !mismatch ? NEXT : retries < MR ? ISSUE : ERROR;
            DELAY:    state_n = dcnt == '0 ? NEXT : DELAY;
            NEXT:     state_n = last ? DONE : FETCH;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx           <= '0;
            op            <= '0;
            retries       <= '0;
            rdata         <= '0;
            dcnt          <= '0;
            tcnt          <= '0;
            bus.m_addr    <= '0;
            bus.m_subaddr <= '0;
            bus.m_wdata   <= '0;
            err_code      <= '0;
            err_index     <= '0;
        end else begin
            tcnt <= (state == WAIT || state == RB_WAIT) ? tcnt + TW'(1) : '0;
            if (go) begin
                idx       <= '0;
                err_code  <= '0;
                err_index <= '0;
            end
            if (state == DECODE) begin
                op            <= bus.tbl_data[17:16];
                bus.m_subaddr <= bus.tbl_data[15:8];
                bus.m_wdata   <= bus.tbl_data[7:0];
                bus.m_addr    <= {CHIP_ADDR[7:1], 1'b0};
                retries       <= '0;
                dcnt          <= DW'(32'(bus.tbl_data[7:0]) * DELAY_UNIT - 1);
            end
            if (state == DELAY) dcnt <= dcnt - DW'(1);
            if (state == WAIT && bus.m_done && op == 2'b01) bus.m_addr[0] <= 1'b1;
            if (state == RB_WAIT && bus.m_done) rdata <= bus.m_rdata;
            if (state == CHECK && mismatch) begin
                retries       <= retries + 4'd1;
                bus.m_addr[0] <= 1'b0;
            end
            if (state == NEXT) idx <= idx + (TBL_AW + 1)'(1);
            if (state_n == ERROR && state != ERROR) begin
                err_code  <= state == CHECK ? 2'b01 : 2'b10;
                err_index <= idx[TBL_AW-1:0];
            end
        end
    end
endmodule

// File: tb/tb_sccb_init_seq.sv
// tb_sccb_init_seq: randomized scoreboard bench for sccb_init_seq against a transaction-level model
module tb_sccb_init_seq;
    localparam int AW = 6, NUM = 40, DU = 10, MR = 2, TO = 100;

    typedef struct packed {
        logic       rw;
        logic [7:0] addr;
        logic [7:0] sub;
        logic [7:0] wdata;
    } txn_t;

    logic clk = 0, reset = 1, start = 0;
    logic busy, done, error;
    logic [1:0] err_code;
    logic [AW-1:0] err_index;

    sccb_init_seq_if #(.TBL_AW(AW)) bus ();

    sccb_init_seq #(.CHIP_ADDR(8'h42), .TBL_AW(AW), .NUM_CMDS(NUM), .DELAY_UNIT(DU),
                    .MAX_RETRY(MR), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus), .busy(busy), .done(done),
        .error(error), .err_code(err_code), .err_index(err_index)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0, fin_cnt = 0, end_cyc = 0, s_cyc = 0;
    int lat_cfg = 10, xb_cfg = 0, bad_cfg = 0, hang_cfg = 0, scen = 0;
    logic exp_done, exp_error;
    logic [1:0] exp_code;
    logic [AW-1:0] exp_idx;
    logic [17:0] tbl [2**AW];
    logic [7:0] regs [256];
    txn_t exp_q [$];
    int mst_cyc [$];
    int mdone_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) bus.tbl_data <= tbl[bus.tbl_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: walk the table by opcode meaning, listing the bus transactions and the final status.
    task automatic model(input int bad, input int hang);
        int n = 0;
        exp_done = 1; exp_error = 0; exp_code = 0; exp_idx = 0;
        for (int i = 0; i < NUM; i++) begin
            logic [1:0] op;
            op = tbl[i][17:16];
            if (op == 2'd3) return;
            if (op == 2'd2) continue;
            for (int r = 0; r <= MR; r++) begin
                exp_q.push_back({1'b0, 8'h42, tbl[i][15:8], tbl[i][7:0]});
                n++;
                if (n == hang) begin
                    exp_done = 0; exp_error = 1; exp_code = 2; exp_idx = AW'(i);
                    return;
                end
                if (op == 2'd0) break;
                exp_q.push_back({1'b1, 8'h43, tbl[i][15:8], tbl[i][7:0]});
                n++;
                if (n == hang) begin
                    exp_done = 0; exp_error = 1; exp_code = 2; exp_idx = AW'(i);
                    return;
                end
                if (bad == 0) break;
                bad--;
                if (r == MR) begin
                    exp_done = 0; exp_error = 1; exp_code = 1; exp_idx = AW'(i);
                    return;
                end
            end
        end
    endtask

    // SCCB master model: busy from request until done, optional corrupted reads or a hung transfer.
    initial begin
        int rd_n, tx_n, my_scen, lat, xb;
        logic rw;
        logic [7:0] sub, wd;
        rd_n = 0; tx_n = 0; my_scen = -1;
        bus.m_done = 0; bus.m_busy = 0; bus.m_rdata = 0;
        forever begin
            @(negedge clk);
            if (bus.m_start) begin
                if (my_scen != scen) begin my_scen = scen; rd_n = 0; tx_n = 0; end
                tx_n++;
                rw = bus.m_rw; sub = bus.m_subaddr; wd = bus.m_wdata;
                lat = lat_cfg > 0 ? lat_cfg : int'($urandom_range(12, 1));
                xb = xb_cfg > 0 ? int'($urandom_range(xb_cfg, 0)) : 0;
                @(posedge clk); #1 bus.m_busy = 1;
                for (int k = 1; k < lat; k++) begin @(posedge clk); #1; end
                if (tx_n != hang_cfg) begin
                    if (!rw) regs[sub] = wd;
                    else begin
                        rd_n++;
                        bus.m_rdata = rd_n <= bad_cfg ? (regs[sub] == 8'h00 ? 8'hFF : 8'h00) : regs[sub];
                    end
                    bus.m_done = 1;
                end
                @(posedge clk); #1 bus.m_done = 0;
                for (int k = 0; k < xb; k++) begin @(posedge clk); #1; end
                bus.m_busy = 0;
            end
        end
    end

    // Monitor: compares each request and each completion against what the model queued.
    initial begin
        logic prev_start, prev_fin;
        txn_t t;
        prev_start = 0; prev_fin = 0;
        forever begin
            @(negedge clk);
            if (bus.m_start) begin
                mst_cyc.push_back(cyc);
                chk("start_while_busy", bus.m_busy, 0);
                chk("start_back_to_back", prev_start, 0);
                chk("txn_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    t = exp_q.pop_front();
                    chk("m_rw", bus.m_rw, t.rw);
                    chk("m_addr", bus.m_addr, t.addr);
                    chk("m_subaddr", bus.m_subaddr, t.sub);
                    chk("m_wdata", bus.m_wdata, t.wdata);
                end
            end
            if (bus.m_done) mdone_cyc.push_back(cyc);
            if ((done || error) && !prev_fin) begin
                end_cyc = cyc;
                chk("done", done, exp_done);
                chk("error", error, exp_error);
                chk("err_code", err_code, exp_code);
                chk("err_index", err_index, exp_idx);
                chk("txns_left", exp_q.size(), 0);
                fin_cnt++;
            end
            prev_start = bus.m_start;
            prev_fin = done || error;
        end
    end

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_err_code"}, err_code, 0);
        chk({tag, "_err_index"}, err_index, 0);
        chk({tag, "_tbl_addr"}, bus.tbl_addr, 0);
        chk({tag, "_m_start"}, bus.m_start, 0);
        chk({tag, "_m_rw"}, bus.m_rw, 0);
        chk({tag, "_m_addr"}, bus.m_addr, 0);
        chk({tag, "_m_subaddr"}, bus.m_subaddr, 0);
        chk({tag, "_m_wdata"}, bus.m_wdata, 0);
    endtask

    task automatic set_tbl(input int i, input logic [1:0] op, input logic [7:0] sub, input logic [7:0] d);
        tbl[i] = {op, sub, d};
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1;
        s_cyc = cyc;
        @(negedge clk);
        start = 0;
        chk("status_cleared_on_start", {done, error, err_code, err_index}, 0);
    endtask

    task automatic run(input int bad, input int hang, input int lat, input int xb, input int poke);
        int f;
        bad_cfg = bad; hang_cfg = hang; lat_cfg = lat; xb_cfg = xb;
        scen++;
        exp_q.delete(); mst_cyc.delete(); mdone_cyc.delete();
        model(bad, hang);
        f = fin_cnt;
        pulse_start();
        for (int k = 0; k < 20000 && fin_cnt == f; k++) begin
            @(negedge clk);
            start = (k == poke) && busy && !(done || error);
        end
        start = 0;
        chk("run_finished", fin_cnt != f, 1);
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) tbl[i] = {2'b11, 16'h0};
        repeat (3) @(negedge clk);
        chk_idle("reset");
        reset = 0;
        repeat (2) @(negedge clk);

        // Three plain writes then END; fixed 10-cycle master latency.
        set_tbl(0, 2'd0, 8'h11, 8'hA1);
        set_tbl(1, 2'd0, 8'h22, 8'hB2);
        set_tbl(2, 2'd0, 8'h33, 8'hC3);
        set_tbl(3, 2'd3, 8'h00, 8'h00);
        run(0, 0, 10, 0, -1);
        chk("start_to_mstart", mst_cyc.size() > 0 ? mst_cyc[0] - s_cyc : -1, 3);
        chk("mdone_to_next_mstart", (mst_cyc.size() > 1 && mdone_cyc.size() > 0) ? mst_cyc[1] - mdone_cyc[0] : -1, 4);

        // Write-verify with a matching readback.
        set_tbl(0, 2'd1, 8'h12, 8'h80);
        set_tbl(1, 2'd3, 8'h00, 8'h00);
        run(0, 0, 10, 0, -1);
        chk("wdone_to_read_mstart", (mst_cyc.size() > 1 && mdone_cyc.size() > 0) ? mst_cyc[1] - mdone_cyc[0] : -1, 1);

        // Readback never matches: retries exhaust at entry 2.
        set_tbl(0, 2'd0, 8'h01, 8'h05);
        set_tbl(1, 2'd0, 8'h02, 8'h06);
        set_tbl(2, 2'd1, 8'h12, 8'h80);
        set_tbl(3, 2'd3, 8'h00, 8'h00);
        run(100, 0, 10, 0, -1);

        // Delay of 3 units before the first write.
        set_tbl(0, 2'd2, 8'h00, 8'h03);
        set_tbl(1, 2'd0, 8'h44, 8'h55);
        set_tbl(2, 2'd3, 8'h00, 8'h00);
        run(0, 0, 10, 0, -1);
        chk("delay_start_to_mstart", mst_cyc.size() > 0 ? mst_cyc[0] - s_cyc : -1, 3 + 3 * DU + 3);

        // Master never completes the first transfer.
        set_tbl(0, 2'd0, 8'h66, 8'h77);
        set_tbl(1, 2'd3, 8'h00, 8'h00);
        run(0, 1, 10, 0, -1);
        chk("timeout_latency", mst_cyc.size() > 0 ? end_cyc - mst_cyc[0] : -1, TO + 1);
        run(0, 0, 10, 0, 5);

        // END at index 1 of the full-size table.
        set_tbl(0, 2'd0, 8'h3A, 8'h5C);
        set_tbl(1, 2'd3, 8'h00, 8'h00);
        for (int i = 2; i < NUM; i++) set_tbl(i, 2'd0, 8'(i), 8'(i * 3));
        run(0, 0, 10, 0, -1);

        // Rerun and pull reset while the first write is in flight.
        lat_cfg = 20; hang_cfg = 0; bad_cfg = 0;
        scen++;
        exp_q.delete(); mst_cyc.delete();
        model(0, 0);
        pulse_start();
        for (int k = 0; k < 200 && mst_cyc.size() == 0; k++) @(negedge clk);
        chk("reset_run_issued", mst_cyc.size() != 0, 1);
        repeat (3) @(negedge clk);
        reset = 1;
        #1 chk_idle("midrun_reset");
        repeat (2) @(negedge clk);
        reset = 0;
        exp_q.delete();
        repeat (40) @(negedge clk);
        chk_idle("after_reset");

        // Every entry a write: termination at the last index.
        for (int i = 0; i < NUM; i++) set_tbl(i, 2'd0, 8'(i + 1), 8'(255 - i));
        run(0, 0, 2, 0, -1);

        // Randomized tables, latencies, corrupted reads and occasional hangs.
        for (int s = 0; s < 12; s++) begin
            for (int i = 0; i < NUM; i++) begin
                int r;
                r = int'($urandom_range(99, 0));
                set_tbl(i, r < 50 ? 2'd0 : r < 80 ? 2'd1 : r < 96 ? 2'd2 : 2'd3,
                        8'($urandom), r >= 80 && r < 96 ? 8'($urandom_range(3, 0)) : 8'($urandom));
            end
            run(int'($urandom_range(4, 0)), $urandom_range(3, 0) == 0 ? int'($urandom_range(8, 1)) : 0,
                0, 2, int'($urandom_range(60, 5)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
